mem_stage: RTL and testbench

//  MEM pipeline stage: consumes ex_out_t from EX, performs data-memory or IO load/store over a
//  req/ack bus, and produces the registered mem_out_t consumed by WB. Formats store lanes and

---
 rtl/mem_stage_if.sv | 36 +++
 rtl/mem_stage.sv | 212 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: the two load/store buses driven by the MEM stage.
//  dmem_*  data memory: req/we/addr/be/wdata out, ack/rdata back
//  io_*    IO space:    req/we/addr/wdata out, ack/rdata back
// Request-side signals are registered by the stage. They hold steady from
// the request until the cycle ack is seen. rdata is only sampled in an ack
// cycle of a load.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        io_req;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_ack;
  logic [31:0] io_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata,
    output io_req, io_we, io_addr, io_wdata,
    input  io_ack, io_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata,
    input  io_req, io_we, io_addr, io_wdata,
    output io_ack, io_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage.
// This stage takes ex_out_t from EX. It runs at most one data-memory or IO
// access at a time over req/ack, and it registers mem_out_t for WB.
// Ports:
//  clk, rst    clock; synchronous active-high reset
//  ex_out      EX result. Upstream holds it while mem_stall=1.
//  mem_stall   combinational hold request to IF/ID/EX
//  mem_out     registered result to WB
//  bus         dmem_* / io_* request buses (mem_stage_if.master)
// Stores:
//  - Byte enables are formatted from the size and the low address bits.
//  - Store data is replicated into every lane.
// Loads:
//  - The lane is picked from the low address bits.
//  - The result is sign-extended or zero-extended to 32 bits.
// Misaligned halves and words drop the low address bits. No trap is raised.
package mem_stage_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] op3;
    logic [4:0]  rd;
    logic        w_rd;
    logic        bubble;
    logic        mem_r;
    logic        mem_w;
    logic        io_r;
    logic        io_w;
    logic [1:0]  mem_sz;   // 0 byte, 1 half, 2/3 word
    logic        mem_sx;
  } ex_out_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        w_rd;
    logic        bubble;
  } mem_out_t;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} mem_state_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  ex_out_t    ex_out,
  output logic       mem_stall,
  output mem_out_t   mem_out,
  mem_stage_if.master bus
);

  // ---------------------------------------------------------------- helpers
  function automatic logic [3:0] fmt_be(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      2'd0:    be = 4'b0001 << a;
      2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] fmt_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      2'd0:    w = {4{d[7:0]}};
      2'd1:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [1:0] sz, input logic sx,
                                           input logic [1:0] a, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    r = {{24{sx & b[7]}}, b};
      2'd1:    r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // ------------------------------------------------------------ decode (EX)
  logic is_mem, is_io, access, req_we;
  // Memory wins when both the memory and IO flags are set.
  assign is_mem = ex_out.mem_r | ex_out.mem_w;
  assign is_io  = ~is_mem & (ex_out.io_r | ex_out.io_w);
  assign access = ~ex_out.bubble & (is_mem | is_io);
  assign req_we = is_mem ? ex_out.mem_w : ex_out.io_w;

  // ---------------------------------------------------- latched access info
  logic        sel_io;   // outstanding access is on the IO bus
  logic        we_q;
  logic [1:0]  sz_q;
  logic        sx_q;
  logic [1:0]  lo_q;     // byte offset for load lane select
  logic [4:0]  rd_q;
  logic        w_rd_q;
  logic [31:0] pc_q;
  logic [31:0] res_q;    // alu_res, returned as the result of a store

  logic        bus_ack;
  logic [31:0] bus_rdata;
  assign bus_ack   = sel_io ? bus.io_ack   : bus.dmem_ack;
  assign bus_rdata = sel_io ? bus.io_rdata : bus.dmem_rdata;

  // -------------------------------------------------------------------- FSM
  mem_state_t state, state_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (access)  state_nx = S_BUSY;
      S_BUSY: if (bus_ack) state_nx = S_IDLE;
      default:             state_nx = S_IDLE;
    endcase
  end

  // The stall drops in the ack cycle. Upstream then advances on the same
  // edge that retires the access, so no ex_out is ever issued twice.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      S_IDLE:  mem_stall = access;
      S_BUSY:  mem_stall = ~bus_ack;
      default: mem_stall = 1'b0;
    endcase
  end

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_out        <= '{pc: '0, res: '0, rd: '0, w_rd: 1'b0, bubble: 1'b1};
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_be    <= '0;
      bus.dmem_wdata <= '0;
      bus.io_req     <= 1'b0;
      bus.io_we      <= 1'b0;
      bus.io_addr    <= '0;
      bus.io_wdata   <= '0;
      sel_io         <= 1'b0;
      we_q           <= 1'b0;
      sz_q           <= '0;
      sx_q           <= 1'b0;
      lo_q           <= '0;
      rd_q           <= '0;
      w_rd_q         <= 1'b0;
      pc_q           <= '0;
      res_q          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            // WB sees a bubble while the access is outstanding.
            mem_out <= '{pc: '0, res: '0, rd: '0, w_rd: 1'b0, bubble: 1'b1};
            sel_io  <= is_io;
            we_q    <= req_we;
            sz_q    <= ex_out.mem_sz;
            sx_q    <= ex_out.mem_sx;
            lo_q    <= ex_out.alu_res[1:0];
            rd_q    <= ex_out.rd;
            w_rd_q  <= ex_out.w_rd;
            pc_q    <= ex_out.pc;
            res_q   <= ex_out.alu_res;
            if (is_io) begin
              bus.io_req   <= 1'b1;
              bus.io_we    <= req_we;
              bus.io_addr  <= {ex_out.alu_res[31:2], 2'b00};
              bus.io_wdata <= fmt_wdata(ex_out.mem_sz, ex_out.op3);
            end else begin
              bus.dmem_req   <= 1'b1;
              bus.dmem_we    <= req_we;
              bus.dmem_addr  <= {ex_out.alu_res[31:2], 2'b00};
              bus.dmem_be    <= fmt_be(ex_out.mem_sz, ex_out.alu_res[1:0]);
              bus.dmem_wdata <= fmt_wdata(ex_out.mem_sz, ex_out.op3);
            end
          end else begin
            mem_out <= '{pc: ex_out.pc, res: ex_out.alu_res, rd: ex_out.rd,
                         w_rd: ex_out.w_rd, bubble: ex_out.bubble};
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            bus.dmem_req <= 1'b0;
            bus.io_req   <= 1'b0;
            // A store never writes the register file.
            mem_out <= '{pc: pc_q,
                         res: we_q ? res_q : fmt_load(sz_q, sx_q, lo_q, bus_rdata),
                         rd: rd_q, w_rd: w_rd_q & ~we_q, bubble: 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with hand-computed expectations.
// Inputs are driven 1 time unit after a rising edge. Outputs are checked on
// the falling edge.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  ex_out_t  ex_out;
  logic     mem_stall;
  mem_out_t mem_out;

  mem_stage_if bus();

  mem_stage dut (
    .clk       (clk),
    .rst       (rst),
    .ex_out    (ex_out),
    .mem_stall (mem_stall),
    .mem_out   (mem_out),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic ex_out_t ex_nop();
    ex_out_t e;
    e = '0;
    e.bubble = 1'b1;
    return e;
  endfunction

  function automatic ex_out_t ex_op(input logic [31:0] pc, input logic [31:0] alu,
                                    input logic [31:0] op3, input logic [4:0] rd,
                                    input logic w_rd, input logic [3:0] kind,
                                    input logic [1:0] sz, input logic sx);
    ex_out_t e;
    e = '0;
    e.pc = pc; e.alu_res = alu; e.op3 = op3; e.rd = rd; e.w_rd = w_rd;
    {e.mem_r, e.mem_w, e.io_r, e.io_w} = kind;
    e.mem_sz = sz; e.mem_sx = sx;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ex_out = ex_nop();
    bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    bus.io_ack = 1'b0;   bus.io_rdata = '0;
    edge_(); edge_();
    mid();
    checks++; if (mem_out.bubble !== 1'b1) begin errors++; $display("FAIL rst_bubble got=%b exp=1", mem_out.bubble); end
    checks++; if (mem_out.w_rd !== 1'b0) begin errors++; $display("FAIL rst_w_rd got=%b exp=0", mem_out.w_rd); end
    checks++; if (mem_out.res !== 32'h0) begin errors++; $display("FAIL rst_res got=%h exp=0", mem_out.res); end
    checks++; if (bus.dmem_req !== 1'b0 || bus.io_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b%b exp=00", bus.dmem_req, bus.io_req); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", mem_stall); end
    checks++; if (bus.dmem_be !== 4'h0 || bus.dmem_addr !== 32'h0) begin errors++; $display("FAIL rst_bus got be=%h addr=%h exp 0/0", bus.dmem_be, bus.dmem_addr); end
    edge_();
    rst = 1'b0;
  endtask

  task automatic test_alu();
    edge_();
    ex_out = ex_op(32'h10, 32'h1234, 32'h0, 5'd5, 1'b1, 4'b0000, 2'd0, 1'b0);
    mid();
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b exp=0", mem_stall); end
    edge_();
    ex_out = ex_nop();
    bus.dmem_ack = 1'b1;  // a stray ack while idle must be ignored
    mid();
    checks++; if (mem_out !== '{pc: 32'h10, res: 32'h1234, rd: 5'd5, w_rd: 1'b1, bubble: 1'b0})
      begin errors++; $display("FAIL alu_out got=%h exp pc=10 res=1234 rd=5 w_rd=1 bubble=0", mem_out); end
    edge_();
    mid();
    checks++; if (mem_out.bubble !== 1'b1 || bus.dmem_req !== 1'b0 || mem_stall !== 1'b0)
      begin errors++; $display("FAIL idle_ack got bubble=%b req=%b stall=%b exp 1/0/0", mem_out.bubble, bus.dmem_req, mem_stall); end
    bus.dmem_ack = 1'b0;
  endtask

  task automatic test_load_byte();
    edge_();
    ex_out = ex_op(32'h40, 32'h103, 32'h0, 5'd7, 1'b1, 4'b1000, 2'd0, 1'b1);
    mid();
    checks++; if (mem_stall !== 1'b1 || bus.dmem_req !== 1'b0) begin errors++; $display("FAIL ldb_issue got stall=%b req=%b exp 1/0", mem_stall, bus.dmem_req); end
    edge_();
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h80FF_0000;
    mid();
    checks++; if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 32'h100)
      begin errors++; $display("FAIL ldb_bus got req=%b we=%b addr=%h exp 1/0/100", bus.dmem_req, bus.dmem_we, bus.dmem_addr); end
    checks++; if (mem_stall !== 1'b0 || mem_out.bubble !== 1'b1) begin errors++; $display("FAIL ldb_busy got stall=%b bubble=%b exp 0/1", mem_stall, mem_out.bubble); end
    edge_();
    bus.dmem_ack = 1'b0;
    ex_out = ex_nop();
    mid();
    checks++; if (mem_out !== '{pc: 32'h40, res: 32'hFFFF_FF80, rd: 5'd7, w_rd: 1'b1, bubble: 1'b0})
      begin errors++; $display("FAIL ldb_out got=%h exp pc=40 res=ffffff80 rd=7 w_rd=1", mem_out); end
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL ldb_req_drop got=%b exp=0", bus.dmem_req); end
  endtask

  task automatic test_store();
    logic [31:0] addr [3] = '{32'h102, 32'h101, 32'h10B};
    logic [31:0] op3  [3] = '{32'h0000_ABCD, 32'h1234_5677, 32'hCAFE_F00D};
    logic [1:0]  sz   [3] = '{2'd1, 2'd0, 2'd3};
    logic [3:0]  be   [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wd   [3] = '{32'hABCD_ABCD, 32'h7777_7777, 32'hCAFE_F00D};
    logic [31:0] wa   [3] = '{32'h100, 32'h100, 32'h108};
    for (int i = 0; i < 3; i++) begin
      edge_();
      ex_out = ex_op(32'h200 + i, addr[i], op3[i], 5'd3, 1'b1, 4'b0100, sz[i], 1'b0);
      mid();
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL st%0d_stall got=%b exp=1", i, mem_stall); end
      edge_();
      bus.dmem_ack = 1'b1;
      mid();
      checks++; if (bus.dmem_be !== be[i] || bus.dmem_wdata !== wd[i] || bus.dmem_we !== 1'b1 || bus.dmem_addr !== wa[i])
        begin errors++; $display("FAIL st%0d_bus got be=%b wd=%h we=%b a=%h exp be=%b wd=%h we=1 a=%h",
                                 i, bus.dmem_be, bus.dmem_wdata, bus.dmem_we, bus.dmem_addr, be[i], wd[i], wa[i]); end
      edge_();
      bus.dmem_ack = 1'b0;
      ex_out = ex_nop();
      mid();
      checks++; if (mem_out.bubble !== 1'b0 || mem_out.w_rd !== 1'b0 || mem_out.res !== addr[i])
        begin errors++; $display("FAIL st%0d_out got bubble=%b w_rd=%b res=%h exp 0/0/%h", i, mem_out.bubble, mem_out.w_rd, mem_out.res, addr[i]); end
    end
  endtask

  task automatic test_io_wait();
    int stall_cnt = 0;
    int req_cnt   = 0;
    bit bad       = 1'b0;
    edge_();
    // Size 3 is a word; the address low bits are dropped.
    ex_out = ex_op(32'h80, 32'h2003, 32'h0, 5'd9, 1'b1, 4'b0010, 2'd3, 1'b1);
    mid();
    if (mem_stall) stall_cnt++;
    for (int b = 1; b <= 6; b++) begin
      edge_();
      if (b == 6) begin bus.io_ack = 1'b1; bus.io_rdata = 32'hDEAD_BEEF; end
      mid();
      if (mem_stall) stall_cnt++;
      if (bus.io_req && !bus.io_ack) req_cnt++;
      if (bus.io_addr !== 32'h2000 || bus.io_req !== 1'b1 || bus.dmem_req !== 1'b0) bad = 1'b1;
    end
    edge_();
    bus.io_ack = 1'b0;
    ex_out = ex_nop();
    mid();
    checks++; if (stall_cnt != 6) begin errors++; $display("FAIL io_stall_cycles got=%0d exp=6", stall_cnt); end
    checks++; if (req_cnt != 5) begin errors++; $display("FAIL io_req_wait_cycles got=%0d exp=5", req_cnt); end
    checks++; if (bad) begin errors++; $display("FAIL io_bus_stable got=unstable exp=stable addr 2000"); end
    checks++; if (mem_out !== '{pc: 32'h80, res: 32'hDEAD_BEEF, rd: 5'd9, w_rd: 1'b1, bubble: 1'b0})
      begin errors++; $display("FAIL io_out got=%h exp pc=80 res=deadbeef rd=9", mem_out); end
    checks++; if (bus.io_req !== 1'b0) begin errors++; $display("FAIL io_req_drop got=%b exp=0", bus.io_req); end
  endtask

  task automatic test_back_to_back();
    edge_();
    ex_out = ex_op(32'h100, 32'h200, 32'h0, 5'd1, 1'b1, 4'b1000, 2'd2, 1'b0);
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_2222;
    mid();
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL b2b_a_stall got=%b exp=1", mem_stall); end
    edge_();
    mid();
    checks++; if (mem_stall !== 1'b0 || mem_out.bubble !== 1'b1) begin errors++; $display("FAIL b2b_a_busy got stall=%b bubble=%b exp 0/1", mem_stall, mem_out.bubble); end
    edge_();
    ex_out = ex_op(32'h104, 32'h206, 32'h0, 5'd2, 1'b1, 4'b1000, 2'd1, 1'b0);
    bus.dmem_rdata = 32'h8001_7FFE;
    mid();
    checks++; if (mem_out !== '{pc: 32'h100, res: 32'h1111_2222, rd: 5'd1, w_rd: 1'b1, bubble: 1'b0})
      begin errors++; $display("FAIL b2b_a_out got=%h exp res=11112222 rd=1", mem_out); end
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL b2b_b_stall got=%b exp=1", mem_stall); end
    edge_();
    mid();
    checks++; if (mem_out.bubble !== 1'b1) begin errors++; $display("FAIL b2b_gap got bubble=%b exp=1", mem_out.bubble); end
    edge_();
    ex_out = ex_nop();
    bus.dmem_ack = 1'b0;
    mid();
    checks++; if (mem_out !== '{pc: 32'h104, res: 32'h0000_8001, rd: 5'd2, w_rd: 1'b1, bubble: 1'b0})
      begin errors++; $display("FAIL b2b_b_out got=%h exp res=00008001 rd=2", mem_out); end
  endtask

  task automatic test_reset_mid();
    edge_();
    ex_out = ex_op(32'h300, 32'h300, 32'h0, 5'd4, 1'b1, 4'b1000, 2'd0, 1'b0);
    mid();
    edge_();
    rst = 1'b1;
    mid();
    checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL rmid_busy got req=%b exp=1", bus.dmem_req); end
    edge_();
    rst = 1'b0;
    ex_out = ex_nop();
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;  // late ack
    mid();
    checks++; if (bus.dmem_req !== 1'b0 || mem_out.bubble !== 1'b1 || mem_stall !== 1'b0)
      begin errors++; $display("FAIL rmid_after got req=%b bubble=%b stall=%b exp 0/1/0", bus.dmem_req, mem_out.bubble, mem_stall); end
    edge_();
    mid();
    checks++; if (mem_out.bubble !== 1'b1 || mem_out.w_rd !== 1'b0 || bus.dmem_req !== 1'b0)
      begin errors++; $display("FAIL rmid_late_ack got bubble=%b w_rd=%b req=%b exp 1/0/0", mem_out.bubble, mem_out.w_rd, bus.dmem_req); end
    bus.dmem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_store();
    test_io_wait();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
